mult_seq_ctrl: RTL and testbench

//  Sequencer that builds a W x W unsigned product from one shared 4x4 combinational

---
 rtl/mult_seq_ctrl.sv | 90 +++++++++
 tb/tb_mult_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: W x W unsigned multiplier sequenced over one shared 4x4 array multiplier
module multiplier (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);
   always_comb begin
      p_o = '0;
      for (int r = 0; r < 4; r++) p_o = p_o + ({4'b0, a_i & {4{b_i[r]}}} << r);
   end
endmodule

module mult_seq_ctrl #(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   product,
   output logic             busy
);
   localparam int K  = W / 4;
   localparam int IW = K > 1 ? $clog2(K) : 1;
   localparam int SW = $clog2(2 * W) + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q;
   logic [W-1:0]     ra_q, rb_q;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [IW-1:0]    i_q, j_q;
   logic [7:0]       pp;
   logic [SW-1:0]    sh;
   logic             j_end, last;
   if (W % 4 != 0 || W < 4) begin : g_bad_w
      $error("W must be a positive multiple of 4");
   end
   multiplier u_mul (
      .a_i(ra_q[{i_q, 2'b00} +: 4]),
      .b_i(rb_q[{j_q, 2'b00} +: 4]),
      .p_o(pp)
   );
   assign sh       = SW'(4 * (int'(i_q) + int'(j_q)));
   assign acc_d    = acc_q + ((2 * W)'(pp) << sh);
   assign j_end    = j_q == IW'(K - 1);
   assign last     = j_end && i_q == IW'(K - 1);
   assign in_ready = state_q == IDLE;
   assign busy     = state_q != IDLE;
   // DONE spends its first cycle loading the output registers, so out_valid rises one edge after CALC ends
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ra_q      <= '0;
         rb_q      <= '0;
         acc_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         out_valid <= 1'b0;
         product   <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               ra_q    <= a;
               rb_q    <= b;
               acc_q   <= '0;
               i_q     <= '0;
               j_q     <= '0;
               state_q <= CALC;
            end
            CALC: begin
               acc_q <= acc_d;
               j_q   <= j_end ? '0 : j_q + 1'b1;
               i_q   <= j_end ? (last ? '0 : i_q + 1'b1) : i_q;
               if (last) state_q <= DONE;
            end
            DONE: if (!out_valid) begin
               out_valid <= 1'b1;
               product   <= acc_q;
            end else if (out_ready) begin
               out_valid <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: scoreboard bench for mult_seq_ctrl at W=8 and W=12
module tb_mult_seq_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic        in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid, busy;
   logic [7:0]  a = '0, b = '0;
   logic [15:0] product;
   logic        in_valid12 = 1'b0, out_ready12 = 1'b1, in_ready12, out_valid12, busy12;
   logic [11:0] a12 = '0, b12 = '0;
   logic [23:0] product12;
   int checks = 0, errors = 0;
   logic [15:0] q8[$];
   logic [23:0] q12[$];
   logic [7:0]  c[8] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'hF0, 8'hFF, 8'h80, 8'h7F};

   mult_seq_ctrl #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
   );
   mult_seq_ctrl #(.W(12)) dut12 (
      .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12), .a(a12), .b(b12),
      .out_valid(out_valid12), .out_ready(out_ready12), .product(product12), .busy(busy12)
   );

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, got, exp);
      end
   endtask

   task automatic mon8();
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (q8.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected8 got %h expected none", product);
            end else chk("product8", product, q8.pop_front());
         end
      end
   endtask

   task automatic mon12();
      forever begin
         @(negedge clk);
         if (!rst && out_valid12 && out_ready12) begin
            if (q12.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected12 got %h expected none", product12);
            end else chk("product12", product12, q12.pop_front());
         end
      end
   endtask

   task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input bit push);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("in_ready_wait8", in_ready, 1);
      a = x;
      b = y;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) q8.push_back(exp);
   endtask

   task automatic send12(input logic [11:0] x, input logic [11:0] y);
      int n = 0;
      while (!in_ready12 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready12) chk("in_ready_wait12", in_ready12, 1);
      a12 = x;
      b12 = y;
      in_valid12 = 1'b1;
      @(posedge clk); #1;
      in_valid12 = 1'b0;
      q12.push_back(24'(x) * 24'(y));
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q8.size() > 0 || q12.size() > 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain8", q8.size(), 0);
      chk("drain12", q12.size(), 0);
   endtask

   initial begin
      int n;
      logic [7:0] x, y;
      logic [11:0] x12, y12;
      fork
         mon8();
         mon12();
      join_none
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_product", product, 0);
      @(posedge clk); #1;
      send8(8'hFF, 8'hFF, 16'hFE01, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 5);
      @(posedge clk); #1;
      chk("valid_one_cycle", out_valid, 0);
      send8(8'h00, 8'hA5, 16'h0000, 1);
      send8(8'h0F, 8'h10, 16'h00F0, 1);
      send8(8'h80, 8'h02, 16'h0100, 1);
      send8(8'h0F, 8'h0F, 16'h00E1, 1);
      send8(8'hF0, 8'h0F, 16'h0E10, 1);
      send8(8'h01, 8'hFF, 16'h00FF, 1);
      wait_drain();
      out_ready = 1'b0;
      send8(8'hAB, 8'hCD, 16'h88EF, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_product", product, 16'h88EF);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", in_ready, 1);
      send8(8'h12, 8'h34, 16'h03A8, 1);
      a = 8'h33;
      b = 8'h44;
      in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain();
      repeat (8) @(posedge clk);
      #1;
      chk("drop_idle", in_ready, 1);
      send8(8'h5A, 8'h5A, 16'h0000, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) send8(c[i], c[j], 16'(c[i]) * 16'(c[j]), 1);
      for (int k = 0; k < 1500; k++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         send8(x, y, 16'(x) * 16'(y), 1);
      end
      wait_drain();
      send12(12'hFFF, 12'hFFF);
      send12(12'h000, 12'hABC);
      send12(12'h800, 12'h002);
      for (int k = 0; k < 600; k++) begin
         x12 = 12'($urandom);
         y12 = 12'($urandom);
         send12(x12, y12);
      end
      wait_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
